// File: rtl/uart_mmio_bridge_if.sv
// CPU-side memory-mapped bus for the UART bridge.
// The bridge is the slave; the CPU (or bench) is the master.
interface uart_mmio_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output addr, we, re, wdata,
        input  rdata
    );

    modport slave (
        input  addr, we, re, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between a CPU bus and a UART controller: TX sequencer, RX capture.
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; else one holding register.
module uart_mmio_bridge #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int UART_Nbit     = 8,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_bridge_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  rx_flag,
    input  logic                  tx_flag,
    output logic [DATA_WIDTH-1:0] uart_tx,
    output logic                  enable_StoreTxbuff,
    output logic                  Start_Tx,
    output logic                  clr_rx_flag,
    output logic                  clr_tx_flag
);

    localparam logic [ADDR_WIDTH-1:0] A_TX = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_RX = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_ST = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_CT = ADDR_WIDTH'(12);

    typedef enum logic [2:0] {
        T_IDLE, T_LOAD, T_START, T_WAIT, T_CLEAR
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE, R_CLEAR, R_WAITLOW
    } rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic                  start_cnt_q, start_cnt_d;
    logic [DATA_WIDTH-1:0] uart_tx_q, uart_tx_d;
    logic                  rx_overflow_q, rx_overflow_d;

    logic                 wr_tx, wr_ct, rd_rx;
    logic                 sel_rx, sel_st;
    logic                 tx_busy;
    logic                 push, pop, accept, ovf_set;
    logic                 rx_not_empty, rx_full;
    logic [UART_Nbit-1:0] rx_byte, rx_head;
    logic                 unused_bits;

    assign unused_bits = ^{uart_rx_data, bus.wdata, RX_FIFO_DEPTH[0]};

    assign sel_rx = (bus.addr == A_RX);
    assign sel_st = (bus.addr == A_ST);
    assign wr_tx  = bus.we && (bus.addr == A_TX);
    assign wr_ct  = bus.we && (bus.addr == A_CT) && bus.wdata[2];
    assign rd_rx  = bus.re && sel_rx;

    assign uart_tx = uart_tx_q;
    assign tx_busy = (tx_state_q != T_IDLE);

    always_comb begin
        tx_state_d         = tx_state_q;
        start_cnt_d        = start_cnt_q;
        uart_tx_d          = uart_tx_q;
        enable_StoreTxbuff = 1'b0;
        Start_Tx           = 1'b0;
        clr_tx_flag        = 1'b1;
        unique case (tx_state_q)
            T_IDLE: begin
                if (wr_tx) begin
                    uart_tx_d  = DATA_WIDTH'(bus.wdata[UART_Nbit-1:0]);
                    tx_state_d = T_LOAD;
                end
            end
            T_LOAD: begin
                enable_StoreTxbuff = 1'b1;
                start_cnt_d        = 1'b0;
                tx_state_d         = T_START;
            end
            T_START: begin
                // Start_Tx is held for two cycles
                Start_Tx    = 1'b1;
                start_cnt_d = 1'b1;
                if (start_cnt_q) tx_state_d = T_WAIT;
            end
            T_WAIT: begin
                if (tx_flag) tx_state_d = T_CLEAR;
            end
            T_CLEAR: begin
                clr_tx_flag = 1'b0;
                tx_state_d  = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        clr_rx_flag = 1'b1;
        push        = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (rx_flag) begin
                    push       = 1'b1;
                    rx_state_d = R_CLEAR;
                end
            end
            R_CLEAR: begin
                clr_rx_flag = 1'b0;
                rx_state_d  = R_WAITLOW;
            end
            R_WAITLOW: begin
                // Wait for the flag to drop so one character gives one push
                if (!rx_flag) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    assign rx_byte = uart_rx_data[UART_Nbit-1:0];
    assign pop     = rd_rx && rx_not_empty;
    assign accept  = push && (!rx_full || pop);
    assign ovf_set = push && rx_full && !pop;

    assign rx_overflow_d = ovf_set || (rx_overflow_q && !wr_ct);

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);

    logic [UART_Nbit-1:0] mem_q [RX_FIFO_DEPTH];
    logic [UART_Nbit-1:0] mem_d [RX_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            mem_d[wr_ptr_q] = rx_byte;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (accept && !pop) cnt_d = cnt_q + (PW+1)'(1);
        else if (pop && !accept) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rx_head      = mem_q[rd_ptr_q];
    assign rx_not_empty = (cnt_q != '0);
    assign rx_full      = (cnt_q == (PW+1)'(RX_FIFO_DEPTH));
`else
    logic [UART_Nbit-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (pop) valid_d = 1'b0;
        if (accept) begin
            hold_d  = rx_byte;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_head      = hold_q;
    assign rx_not_empty = valid_q;
    assign rx_full      = valid_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q    <= T_IDLE;
            rx_state_q    <= R_IDLE;
            start_cnt_q   <= 1'b0;
            uart_tx_q     <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            rx_state_q    <= rx_state_d;
            start_cnt_q   <= start_cnt_d;
            uart_tx_q     <= uart_tx_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (1'b1)
            sel_rx: if (rx_not_empty) bus.rdata = DATA_WIDTH'(rx_head);
            sel_st: bus.rdata = DATA_WIDTH'({rx_full, rx_overflow_q,
                                             tx_busy, rx_not_empty});
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed, table-driven bench for uart_mmio_bridge.
// Each row drives one cycle and checks rdata, uart_tx and the four strobes.
module tb_uart_mmio_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] uart_rx_data;
  logic        rx_flag;
  logic        tx_flag;
  logic [31:0] uart_tx;
  logic        enable_StoreTxbuff;
  logic        Start_Tx;
  logic        clr_rx_flag;
  logic        clr_tx_flag;

  uart_mmio_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus();

  uart_mmio_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8),
    .UART_Nbit(8), .RX_FIFO_DEPTH(4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .uart_rx_data       (uart_rx_data),
    .rx_flag            (rx_flag),
    .tx_flag            (tx_flag),
    .uart_tx            (uart_tx),
    .enable_StoreTxbuff (enable_StoreTxbuff),
    .Start_Tx           (Start_Tx),
    .clr_rx_flag        (clr_rx_flag),
    .clr_tx_flag        (clr_tx_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef UART_RX_FIFO_EN
  localparam int          D   = 4;
  localparam logic [31:0] ST1 = 32'h1;
  localparam logic [31:0] ST2 = 32'h3;
`else
  localparam int          D   = 1;
  localparam logic [31:0] ST1 = 32'h9;
  localparam logic [31:0] ST2 = 32'hF;
`endif

  localparam logic [3:0]  I  = 4'b0011;
  localparam logic [3:0]  LD = 4'b1011;
  localparam logic [3:0]  SR = 4'b0111;
  localparam logic [3:0]  CR = 4'b0001;
  localparam logic [3:0]  CT = 4'b0010;
  localparam logic [31:0] T  = 32'h78;

  typedef struct {
    logic        rst;
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        rxf;
    logic [7:0]  rxd;
    logic        txf;
    logic [31:0] erd;
    logic [31:0] etx;
    logic [3:0]  ectl;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void add(
    input logic rst, input logic we,
    input logic re, input logic [7:0] addr,
    input logic [31:0] wdata, input logic rxf,
    input logic [7:0] rxd, input logic txf,
    input logic [31:0] erd, input logic [31:0] etx,
    input logic [3:0] ectl, input string nm);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re;
    v.addr = addr; v.wdata = wdata;
    v.rxf = rxf; v.rxd = rxd; v.txf = txf;
    v.erd = erd; v.etx = etx;
    v.ectl = ectl; v.nm = nm;
    tbl.push_back(v);
  endfunction

  function automatic void push3(
    input logic [7:0] d, input logic [31:0] etx);
    add(1, 0, 0, 8'h14, 0, 1, d, 0, 0, etx, I,
        "rx_push");
    add(1, 0, 0, 8'h14, 0, 0, d, 0, 0, etx, CR,
        "rx_clr_pulse");
    add(1, 0, 0, 8'h14, 0, 0, d, 0, 0, etx, I,
        "rx_waitlow");
  endfunction

  initial begin
    logic [3:0]  got_ctl;
    logic [31:0] e;

    reset = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    uart_rx_data = '0;
    rx_flag = 1'b0; tx_flag = 1'b0;

    #1;
    got_ctl = {enable_StoreTxbuff, Start_Tx,
               clr_rx_flag, clr_tx_flag};
    n_chk++;
    if (uart_tx !== 32'h0 || got_ctl !== I ||
        bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_init: uart_tx=%h ctl=%b rdata=%h",
               uart_tx, got_ctl, bus.rdata);
    end

    add(0, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0, I,
        "reset_status");
    add(0, 0, 1, 8'h04, 0, 0, 0, 0, 0, 0, I,
        "reset_rxdata");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0, I,
        "post_reset_status");

    add(1, 1, 0, 8'h00, 32'h12345678, 0, 0, 0,
        0, 0, I, "tx_write");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 2, T, LD,
        "tx_load");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 2, T, SR,
        "tx_start1");
    add(1, 1, 0, 8'h00, 32'hAB, 0, 0, 0, 0, T, SR,
        "tx_start2_busy_wr");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 2, T, I,
        "tx_wait");
    add(1, 0, 1, 8'h08, 0, 0, 0, 1, 2, T, I,
        "tx_wait_flag");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 2, T, CT,
        "tx_clear");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "tx_idle_again");
    add(1, 0, 1, 8'h0C, 0, 0, 0, 0, 0, T, I,
        "ctrl_read_zero");
    add(1, 1, 1, 8'h10, 32'hFF, 0, 0, 0, 0, T, I,
        "unmapped_wr_rd");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "unmapped_no_effect");

    add(1, 0, 1, 8'h08, 0, 1, 8'h39, 0, 0, T, I,
        "rx_hold0");
    add(1, 0, 1, 8'h08, 0, 1, 8'h39, 0, ST1, T, CR,
        "rx_hold_clr");
    for (int k = 0; k < 8; k++)
      add(1, 0, 1, 8'h08, 0, 1, 8'h39, 0, ST1, T, I,
          "rx_hold_wait");
    add(1, 0, 1, 8'h08, 0, 0, 8'h39, 0, ST1, T, I,
        "rx_flag_low");
    add(1, 0, 1, 8'h04, 0, 0, 0, 0, 32'h39, T, I,
        "rx_read");
    add(1, 0, 1, 8'h04, 0, 0, 0, 0, 0, T, I,
        "rx_read_empty");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "rx_status_empty");

    add(1, 0, 1, 8'h08, 0, 1, 8'h11, 0, 0, T, I,
        "pp_push1");
    add(1, 0, 1, 8'h08, 0, 0, 8'h11, 0, ST1, T, CR,
        "pp_clr1");
    add(1, 0, 1, 8'h08, 0, 0, 8'h11, 0, ST1, T, I,
        "pp_waitlow1");
    add(1, 0, 1, 8'h04, 0, 1, 8'h22, 0, 32'h11, T, I,
        "pp_push_pop");
    add(1, 0, 1, 8'h08, 0, 0, 8'h22, 0, ST1, T, CR,
        "pp_occupancy");
    add(1, 0, 1, 8'h04, 0, 0, 0, 0, 32'h22, T, I,
        "pp_read_new");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "pp_empty");

    for (int k = 1; k <= 5; k++) push3(8'(k), T);
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 32'h0D, T, I,
        "fill_status");
    for (int k = 0; k < 4; k++) begin
`ifdef UART_RX_FIFO_EN
      e = 32'(k + 1);
`else
      e = (k == 0) ? 32'h1 : 32'h0;
`endif
      add(1, 0, 1, 8'h04, 0, 0, 0, 0, e, T, I,
          "fill_read");
    end
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 32'h4, T, I,
        "ovf_sticky");
    add(1, 1, 0, 8'h0C, 32'h4, 0, 0, 0, 0, T, I,
        "ctrl_clear");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "ovf_cleared");

    for (int k = 0; k < D; k++)
      push3(8'(8'hA0 + k), T);
    add(1, 1, 0, 8'h0C, 32'h4, 1, 8'h77, 0, 0, T, I,
        "set_vs_clear");
    add(1, 0, 1, 8'h08, 0, 0, 8'h77, 0, 32'h0D, T, CR,
        "set_wins");
    add(1, 1, 0, 8'h0C, 32'h3, 0, 0, 0, 0, T, I,
        "ctrl_no_bit2");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 32'h0D, T, I,
        "ovf_kept");
    add(1, 1, 0, 8'h0C, 32'h4, 0, 0, 0, 0, T, I,
        "ctrl_clear2");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 32'h09, T, I,
        "ovf_cleared2");
    for (int k = 0; k < D; k++)
      add(1, 0, 1, 8'h04, 0, 0, 0, 0,
          32'(8'hA0 + k), T, I, "drain");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, 0, T, I,
        "drained");

    push3(8'hB1, T);
    push3(8'hB2, T);
    add(1, 1, 0, 8'h00, 32'h1C5, 0, 0, 0, 0, T, I,
        "tx2_write");
    add(1, 0, 0, 8'h14, 0, 0, 0, 0, 0, 32'hC5, LD,
        "tx2_load");
    add(1, 0, 0, 8'h14, 0, 0, 0, 0, 0, 32'hC5, SR,
        "tx2_start1");
    add(1, 0, 0, 8'h14, 0, 0, 0, 0, 0, 32'hC5, SR,
        "tx2_start2");
    add(1, 0, 1, 8'h08, 0, 0, 0, 0, ST2, 32'hC5, I,
        "tx2_wait_status");
    add(0, 0, 1, 8'h08, 0, 0, 0, 1, 0, 0, I,
        "rst_mid_xfer");
    add(0, 0, 1, 8'h04, 0, 0, 0, 1, 0, 0, I,
        "rst_rx_empty");
    for (int k = 0; k < 3; k++)
      add(1, 0, 1, 8'h08, 0, 0, 0, 1, 0, 0, I,
          "post_abort");

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset        = tbl[i].rst;
      bus.we       = tbl[i].we;
      bus.re       = tbl[i].re;
      bus.addr     = tbl[i].addr;
      bus.wdata    = tbl[i].wdata;
      rx_flag      = tbl[i].rxf;
      uart_rx_data = {24'h0, tbl[i].rxd};
      tx_flag      = tbl[i].txf;
      #1;
      got_ctl = {enable_StoreTxbuff, Start_Tx,
                 clr_rx_flag, clr_tx_flag};
      n_chk++;
      if (bus.rdata !== tbl[i].erd ||
          uart_tx !== tbl[i].etx ||
          got_ctl !== tbl[i].ectl) begin
        n_fail++;
        $display("FAIL %s row %0d: rdata=%h uart_tx=%h ctl=%b, expected rdata=%h uart_tx=%h ctl=%b",
                 tbl[i].nm, i, bus.rdata, uart_tx,
                 got_ctl, tbl[i].erd, tbl[i].etx,
                 tbl[i].ectl);
      end
    end

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset    = 1'b1;
      bus.we   = 1'b0;
      bus.re   = 1'b1;
      bus.addr = 8'h08;
      tx_flag  = 1'b1;
      rx_flag  = 1'b0;
      #1;
      n_chk++;
      if (clr_tx_flag !== 1'b1 ||
          clr_rx_flag !== 1'b1 ||
          Start_Tx !== 1'b0 ||
          uart_tx !== 32'h0 ||
          bus.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL expired_wait %0d: clr_tx=%b clr_rx=%b start=%b uart_tx=%h rdata=%h",
                 k, clr_tx_flag, clr_rx_flag,
                 Start_Tx, uart_tx, bus.rdata);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
